// File: rtl/alu_seq_if.sv
// alu_seq_if: handshake and data bundle for the sequential ALU.
//   master modport: operand source / result consumer.
//     Drives in_valid, M, S, A, B, out_ready.
//     Observes in_ready, out_valid, result, carry, zero.
//   slave modport: the ALU itself, with the directions reversed.
interface alu_seq_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic             M;
    logic [1:0]       S;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             zero;

    modport master (
        output in_valid, M, S, A, B, out_ready,
        input  in_ready, out_valid, result, carry, zero
    );

    modport slave (
        input  in_valid, M, S, A, B, out_ready,
        output in_ready, out_valid, result, carry, zero
    );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: WIDTH-bit handshaked ALU with registered result and flags.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : alu_seq_if slave modport
//     in_valid/in_ready   : request handshake; operands M, S, A, B are sampled on accept
//     out_valid/out_ready : result handshake; result, carry and zero are held while stalled
//
// Encoding:
//   M=0 : S selects AND, OR, XOR or NOT A. carry is 0.
//   M=1 : S selects ADD, SUB, INC or SHL.
//     SUB carry means no borrow.
//     SHL shifts A left by B[SHW-1:0], one bit per cycle.
module alu_seq #(
    parameter int unsigned WIDTH = 8
) (
    input logic      clk,
    input logic      rst_n,
    alu_seq_if.slave bus
);
    localparam int unsigned SHW = $clog2(WIDTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;
    logic [SHW-1:0]   cnt_q, cnt_d;

    logic [SHW-1:0]   shamt;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH-1:0] shl_next;
    logic [WIDTH-1:0] op_res;
    logic             op_carry;
    logic             shl_multi;

    assign shamt     = bus.B[SHW-1:0];
    assign add_sum   = {1'b0, bus.A} + {1'b0, bus.B};
    assign shl_next  = {result_q[WIDTH-2:0], 1'b0};
    assign shl_multi = ({bus.M, bus.S} == 3'b111) && (shamt != '0);

    // Single-cycle result. SHL here covers only the shamt == 0 case.
    always_comb begin
        op_res   = '0;
        op_carry = 1'b0;
        case ({bus.M, bus.S})
            3'b000: op_res = bus.A & bus.B;
            3'b001: op_res = bus.A | bus.B;
            3'b010: op_res = bus.A ^ bus.B;
            3'b011: op_res = ~bus.A;
            3'b100: begin
                op_res   = add_sum[WIDTH-1:0];
                op_carry = add_sum[WIDTH];
            end
            3'b101: begin
                op_res   = bus.A - bus.B;
                op_carry = (bus.A >= bus.B);
            end
            3'b110: begin
                op_res   = bus.A + WIDTH'(1);
                op_carry = &bus.A;
            end
            3'b111: op_res = bus.A;
            default: op_res = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    if (shl_multi) begin
                        state_d  = EXEC;
                        result_d = bus.A;
                        carry_d  = 1'b0;
                        cnt_d    = shamt;
                    end else begin
                        state_d  = DONE;
                        result_d = op_res;
                        carry_d  = op_carry;
                        zero_d   = (op_res == '0);
                    end
                end
            end
            EXEC: begin
                result_d = shl_next;
                carry_d  = result_q[WIDTH-1];
                cnt_d    = cnt_q - SHW'(1);
                // The shift on which the counter reaches zero is the last one.
                if (cnt_q == SHW'(1)) begin
                    state_d = DONE;
                    zero_d  = (shl_next == '0);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.result    = result_q;
    assign bus.carry     = carry_q;
    assign bus.zero      = zero_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq with WIDTH = 8.
module tb_alu_seq;
    logic clk;
    logic rst_n;
    int   n_assert;
    int   n_fail;

    alu_seq_if #(.WIDTH(8)) bus ();

    alu_seq #(.WIDTH(8)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits for in_ready with a bounded budget, then presents one request for a single edge.
    task automatic issue(input logic m, input logic [1:0] s, input logic [7:0] a,
                         input logic [7:0] b);
        int guard = 0;
        while (bus.in_ready !== 1'b1 && guard < 50) begin
            step();
            guard++;
        end
        check("issue_ready", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.M        = m;
        bus.S        = s;
        bus.A        = a;
        bus.B        = b;
        step();
        // Garbage operands after the edge must not affect the latched op.
        bus.in_valid = 1'b0;
        bus.A        = 8'h5A;
        bus.B        = 8'h3C;
    endtask

    task automatic release_result(input string tag);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check({tag, "_ovalid_low"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_iready_high"}, 32'(bus.in_ready), 32'd1);
    endtask

    task automatic single(input string tag, input logic m, input logic [1:0] s,
                          input logic [7:0] a, input logic [7:0] b, input logic [7:0] exp_r,
                          input logic exp_c, input logic exp_z);
        issue(m, s, a, b);
        check({tag, "_ovalid"}, 32'(bus.out_valid), 32'd1);
        check({tag, "_result"}, 32'(bus.result), 32'(exp_r));
        check({tag, "_carry"}, 32'(bus.carry), 32'(exp_c));
        check({tag, "_zero"}, 32'(bus.zero), 32'(exp_z));
        release_result(tag);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;

        // Reset with noisy inputs, including a pending request.
        rst_n         = 1'b0;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        bus.M         = 1'($urandom);
        bus.S         = 2'($urandom);
        bus.A         = 8'($urandom);
        bus.B         = 8'($urandom);
        step();
        step();
        check("rst_result", 32'(bus.result), 32'd0);
        check("rst_carry", 32'(bus.carry), 32'd0);
        check("rst_zero", 32'(bus.zero), 32'd0);
        check("rst_ovalid", 32'(bus.out_valid), 32'd0);
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        step();
        check("rst_iready", 32'(bus.in_ready), 32'd1);

        // All eight encodings with A=F0, B=20. B[2:0]=0 makes SHL a zero-amount shift.
        single("and", 1'b0, 2'b00, 8'hF0, 8'h20, 8'h20, 1'b0, 1'b0);
        single("or",  1'b0, 2'b01, 8'hF0, 8'h20, 8'hF0, 1'b0, 1'b0);
        single("xor", 1'b0, 2'b10, 8'hF0, 8'h20, 8'hD0, 1'b0, 1'b0);
        single("not", 1'b0, 2'b11, 8'hF0, 8'h20, 8'h0F, 1'b0, 1'b0);
        single("add", 1'b1, 2'b00, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b0);
        single("sub", 1'b1, 2'b01, 8'hF0, 8'h20, 8'hD0, 1'b1, 1'b0);
        single("inc", 1'b1, 2'b10, 8'hF0, 8'h20, 8'hF1, 1'b0, 1'b0);
        single("shl0a", 1'b1, 2'b11, 8'hF0, 8'h20, 8'hF0, 1'b0, 1'b0);

        // Flag corner cases.
        single("sub_borrow", 1'b1, 2'b01, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0);
        single("sub_equal",  1'b1, 2'b01, 8'h07, 8'h07, 8'h00, 1'b1, 1'b1);
        single("inc_wrap",   1'b1, 2'b10, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b1);

        // Multi-cycle shift: three EXEC cycles, then DONE.
        // A0 -> 40 (c1) -> 80 (c0) -> 00 (c1).
        issue(1'b1, 2'b11, 8'hA0, 8'h03);
        for (int i = 0; i < 3; i++) begin
            check("shl3_exec_iready", 32'(bus.in_ready), 32'd0);
            check("shl3_exec_ovalid", 32'(bus.out_valid), 32'd0);
            step();
        end
        check("shl3_ovalid", 32'(bus.out_valid), 32'd1);
        check("shl3_result", 32'(bus.result), 32'h00);
        check("shl3_carry", 32'(bus.carry), 32'd1);
        check("shl3_zero", 32'(bus.zero), 32'd1);
        release_result("shl3");

        // B=08 gives shamt 0; the upper bits of B are ignored.
        single("shl0b", 1'b1, 2'b11, 8'h81, 8'h08, 8'h81, 1'b0, 1'b0);

        // Backpressure: hold DONE while a new request is presented.
        issue(1'b1, 2'b00, 8'h12, 8'h34);
        bus.in_valid = 1'b1;
        bus.M        = 1'b0;
        bus.S        = 2'b00;
        bus.A        = 8'hFF;
        bus.B        = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_ovalid", 32'(bus.out_valid), 32'd1);
            check("bp_iready", 32'(bus.in_ready), 32'd0);
            check("bp_result", 32'(bus.result), 32'h46);
            check("bp_carry", 32'(bus.carry), 32'd0);
            check("bp_zero", 32'(bus.zero), 32'd0);
        end
        // The DONE -> IDLE edge must not also accept the pending request.
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check("bp_rel_ovalid", 32'(bus.out_valid), 32'd0);
        check("bp_rel_iready", 32'(bus.in_ready), 32'd1);
        check("bp_rel_result", 32'(bus.result), 32'h46);
        // The still-pending AND FF&FF is accepted on the next edge.
        step();
        bus.in_valid = 1'b0;
        check("bp_next_ovalid", 32'(bus.out_valid), 32'd1);
        check("bp_next_result", 32'(bus.result), 32'hFF);
        release_result("bp_next");

        // Reset mid-shift abandons the operation.
        issue(1'b1, 2'b11, 8'h01, 8'h07);
        for (int i = 0; i < 3; i++) begin
            step();
            check("rs_exec_ovalid", 32'(bus.out_valid), 32'd0);
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("rs_result", 32'(bus.result), 32'd0);
        check("rs_carry", 32'(bus.carry), 32'd0);
        check("rs_zero", 32'(bus.zero), 32'd0);
        check("rs_ovalid", 32'(bus.out_valid), 32'd0);
        check("rs_iready", 32'(bus.in_ready), 32'd1);
        for (int i = 0; i < 8; i++) begin
            step();
            check("rs_quiet_ovalid", 32'(bus.out_valid), 32'd0);
        end
        single("rs_add", 1'b1, 2'b00, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
